rx_phase_sync: RTL and testbench

RX_PHASE_SYNC -- requirements
Module: rx_phase_sync

---
 rtl/rx_phase_sync.sv | 129 ++++++++++++
 tb/tb_rx_phase_sync.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_phase_sync.sv
// Symbol-timing recovery: picks the decimation phase with the largest
// mean |rx_in| over a window. Option macro: RX_PHASE_OVERRIDE_EN.
module rx_phase_sync #(
  parameter int UPSAMPLE = 4,
  parameter int IN_NBITS = 8,
  parameter int WIN_LOG2 = 10,
  localparam int PW = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1,
  localparam int AW = IN_NBITS + WIN_LOG2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic signed [IN_NBITS-1:0] rx_in,
`ifdef RX_PHASE_OVERRIDE_EN
  input  logic                       phase_force_en,
  input  logic        [PW-1:0]       phase_force,
`endif
  output logic                       rx_bit,
  output logic                       rx_valid,
  output logic        [PW-1:0]       phase_out,
  output logic                       phase_update
);

  logic [PW-1:0]       ph_cnt;
  logic [WIN_LOG2-1:0] sym_cnt;
  logic [AW-1:0]       acc  [UPSAMPLE];
  logic [AW-1:0]       snap [UPSAMPLE];
  logic [PW-1:0]       ph_est;
  logic [PW-1:0]       ph_sel;
  logic [PW-1:0]       best_idx;
  logic [AW-1:0]       best_val;
  logic [IN_NBITS-1:0] mag;
  logic                win_end;
  logic                load_pend;
  logic                pu_allow;

  // Sample magnitude; the most negative code maps to 2^(IN_NBITS-1)
  always_comb begin
    mag = rx_in[IN_NBITS-1] ? IN_NBITS'(-rx_in) : IN_NBITS'(rx_in);
  end

  assign win_end = enable
                && (ph_cnt == PW'(UPSAMPLE - 1))
                && (sym_cnt == '1);

  // Argmax over the snapshot; strict compare keeps the lowest index on ties
  always_comb begin
    best_val = snap[0];
    best_idx = '0;
    for (int i = 1; i < UPSAMPLE; i++) begin
      if (snap[i] > best_val) begin
        best_val = snap[i];
        best_idx = PW'(i);
      end
    end
  end

  // Decimation phase: forced value when overridden, else the estimate
  always_comb begin
`ifdef RX_PHASE_OVERRIDE_EN
    ph_sel   = phase_force_en ? phase_force : ph_est;
    pu_allow = ~phase_force_en;
`else
    ph_sel   = ph_est;
    pu_allow = 1'b1;
`endif
  end

  assign phase_out = ph_sel;

  // Phase and symbol counters advance on accepted samples
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_cnt  <= '0;
      sym_cnt <= '0;
    end else if (enable) begin
      ph_cnt <= ph_cnt + PW'(1);
      if (ph_cnt == PW'(UPSAMPLE - 1))
        sym_cnt <= sym_cnt + WIN_LOG2'(1);
    end
  end

  // Per-phase magnitude accumulators, snapshotted and cleared at window end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < UPSAMPLE; i++) begin
        acc[i]  <= '0;
        snap[i] <= '0;
      end
    end else if (enable) begin
      for (int i = 0; i < UPSAMPLE; i++) begin
        if (win_end) begin
          snap[i] <= acc[i]
                   + ((PW'(i) == ph_cnt) ? AW'(mag) : AW'(0));
          acc[i]  <= '0;
        end else if (PW'(i) == ph_cnt) begin
          acc[i] <= acc[i] + AW'(mag);
        end
      end
    end
  end

  // Load the estimate one edge after window end, enable or not
  always_ff @(posedge clk) begin
    if (rst) begin
      load_pend    <= 1'b0;
      ph_est       <= '0;
      phase_update <= 1'b0;
    end else begin
      load_pend    <= win_end;
      phase_update <= load_pend & pu_allow;
      if (load_pend)
        ph_est <= best_idx;
    end
  end

  // Slice the sample at the selected phase; zero decides as 1
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_bit   <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= enable && (ph_cnt == ph_sel);
      if (enable && (ph_cnt == ph_sel))
        rx_bit <= ~rx_in[IN_NBITS-1];
    end
  end

endmodule

// File: tb/tb_rx_phase_sync.sv
// Directed bench for rx_phase_sync with a 4-symbol window and a
// reference model feeding an rx_bit scoreboard.
module tb_rx_phase_sync;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic signed [7:0] rx_in = '0;
  logic              rx_bit;
  logic              rx_valid;
  logic [1:0]        phase_out;
  logic              phase_update;
`ifdef RX_PHASE_OVERRIDE_EN
  logic              phase_force_en = 1'b0;
  logic [1:0]        phase_force = '0;
`endif

  rx_phase_sync #(
    .UPSAMPLE(4),
    .IN_NBITS(8),
    .WIN_LOG2(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .rx_in       (rx_in),
`ifdef RX_PHASE_OVERRIDE_EN
    .phase_force_en(phase_force_en),
    .phase_force (phase_force),
`endif
    .rx_bit      (rx_bit),
    .rx_valid    (rx_valid),
    .phase_out   (phase_out),
    .phase_update(phase_update)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit exp_q[$];
  bit seen[$];

  int m_ph, m_sym, m_out, m_best;
  int m_acc[4];
  bit m_pend, m_valid, m_pu;
  logic prev_valid = 1'b0;
  int k = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    m_ph = 0; m_sym = 0; m_out = 0; m_best = 0;
    m_pend = 0; m_valid = 0; m_pu = 0;
    for (int i = 0; i < 4; i++) m_acc[i] = 0;
    exp_q.delete();
  endtask

  task automatic step(input logic en, input logic signed [7:0] v);
    int mag;
    int best;
    enable = en;
    rx_in  = v;
    @(posedge clk);
    if (rst) begin
      m_clear();
    end else begin
      m_pu    = m_pend;
      m_valid = en && (m_ph == m_out);
      if (m_valid) exp_q.push_back(~v[7]);
      if (m_pend) m_out = m_best;
      m_pend = 0;
      if (en) begin
        mag = (v < 0) ? -int'(v) : int'(v);
        m_acc[m_ph] += mag;
        if (m_ph == 3 && m_sym == 3) begin
          best = 0;
          for (int i = 1; i < 4; i++)
            if (m_acc[i] > m_acc[best]) best = i;
          m_best = best;
          m_pend = 1;
          for (int i = 0; i < 4; i++) m_acc[i] = 0;
        end
        m_ph = (m_ph + 1) % 4;
        if (m_ph == 0) m_sym = (m_sym + 1) % 4;
      end
    end
    #1;
    chk("rx_valid", rx_valid, m_valid);
    chk("phase_update", phase_update, m_pu);
    chk("phase_out", phase_out, m_out);
    chk("valid_consec", prev_valid & rx_valid, 0);
    if (rx_valid === 1'b1) begin
      seen.push_back(rx_bit);
      chk("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("rx_bit", rx_bit, exp_q.pop_front());
    end
    prev_valid = rx_valid;
  endtask

  function automatic logic signed [7:0] pat(input int kind, input int idx);
    int ph;
    int sym;
    ph  = idx % 4;
    sym = (idx / 4) % 4;
    pat = '0;
    case (kind)
      0: case (ph)
           0: pat = 8'sd10;
           1: pat = 8'sd20;
           2: pat = 8'sd100;
           default: pat = 8'sd30;
         endcase
      1: pat = 8'sd50;
      2: case (ph)
           1: pat = -8'sd128;
           3: pat = 8'sd127;
           default: pat = '0;
         endcase
      default: if (ph == 0)
        case (sym)
          0: pat = 8'sd5;
          1: pat = -8'sd5;
          2: pat = 8'sd0;
          default: pat = -8'sd1;
        endcase
    endcase
  endfunction

  task automatic run(input int n, input bit toggle, input int kind);
    logic en;
    for (int s = 0; s < n; s++) begin
      en = toggle ? ((s % 2) == 0) : 1'b1;
      step(en, pat(kind, k));
      if (en) k++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 8'sd77);
    chk("rst_rx_bit", rx_bit, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_phase_out", phase_out, 0);
    chk("rst_phase_update", phase_update, 0);
    rst = 1'b0;
    k = 0;
    seen.delete();
  endtask

  initial begin
    bit exp4[4];
    exp4 = '{1'b1, 1'b0, 1'b1, 1'b0};
    m_clear();

    do_reset();

    // Phase 2 strongest
    run(16, 1'b0, 0);
    chk("t1_no_early_pu", phase_update, 0);
    run(1, 1'b0, 0);
    chk("t1_pu", phase_update, 1);
    chk("t1_phase", phase_out, 2);
    step(1'b1, pat(0, k)); k++;
    chk("t1_pu_single", phase_update, 0);

    // All equal: tie to phase 0, pulses every window
    do_reset();
    run(16, 1'b0, 1);
    run(1, 1'b0, 1);
    chk("t2_pu1", phase_update, 1);
    chk("t2_phase1", phase_out, 0);
    run(15, 1'b0, 1);
    run(1, 1'b0, 1);
    chk("t2_pu2", phase_update, 1);
    chk("t2_phase2", phase_out, 0);

    // -128 beats 127
    do_reset();
    run(16, 1'b0, 2);
    run(1, 1'b0, 2);
    chk("t3_pu", phase_update, 1);
    chk("t3_phase", phase_out, 1);

    // Slicer at phase 0
    do_reset();
    run(16, 1'b0, 3);
    chk("t4_nbits", seen.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < seen.size()) chk("t4_bit", seen[i], exp4[i]);
    run(1, 1'b0, 3);
    chk("t4_phase", phase_out, 0);

    // Toggling enable
    do_reset();
    run(32, 1'b1, 0);
    chk("t5_pu", phase_update, 1);
    chk("t5_phase", phase_out, 2);

    // Reset mid-window
    do_reset();
    run(10, 1'b0, 0);
    do_reset();
    run(16, 1'b0, 0);
    chk("t6_no_early_pu", phase_update, 0);
    run(1, 1'b0, 0);
    chk("t6_pu", phase_update, 1);
    chk("t6_phase", phase_out, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
